// File: rtl/booth_div_16by8.sv
// rtl/booth_div_16by8.sv - sequential signed restoring divider, 2*DW-bit dividend by DW-bit divisor
module booth_div_16by8 #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            rdy,
  output logic            busy,
  output logic            div_zero,
  output logic            overflow
);

  localparam int ITER = 2 * DW;
  localparam int CW   = $clog2(ITER);

  localparam logic [DW-1:0]   SAT_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]   SAT_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [2*DW-1:0] POS_LIM = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic [2*DW-1:0] NEG_LIM = {{DW{1'b0}}, 1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nx;

  // dq starts as the dividend magnitude; quotient bits shift in at the bottom
  // as dividend bits shift out of the top, so after ITER steps it holds Qu.
  logic [2*DW-1:0] dq;
  logic [DW-1:0]   dvs_mag;
  logic [DW-1:0]   prem;
  logic            sign_q;
  logic            sign_r;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic [2*DW-1:0] dvd_abs;
  logic [DW-1:0]   dvs_abs;
  logic [DW:0]     shifted;
  logic [DW:0]     diff;
  logic            fits;
  logic            q_ovf;
  logic [DW-1:0]   q_lo;

  assign accept  = start && ((state == IDLE) || (state == DONE));
  assign dvd_abs = dividend[2*DW-1] ? (~dividend + 1'b1) : dividend;
  assign dvs_abs = divisor[DW-1] ? (~divisor + 1'b1) : divisor;

  // Partial remainder stays below the divisor magnitude, so DW+1 bits hold
  // the shifted value and DW bits hold whatever is kept.
  assign shifted = {prem, dq[2*DW-1]};
  assign diff    = shifted - {1'b0, dvs_mag};
  assign fits    = (shifted >= {1'b0, dvs_mag});

  // Negative quotients may reach one further in magnitude than positive ones.
  assign q_ovf = sign_q ? (dq > NEG_LIM) : (dq > POS_LIM);
  assign q_lo  = dq[DW-1:0];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; a zero divisor skips the iteration phase entirely
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = (divisor == '0) ? FIX : CALC;
      CALC:       if (cnt == CW'(ITER - 1)) state_nx = FIX;
      FIX:        state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, restoring steps, sign/range correction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dq        <= '0;
      dvs_mag   <= '0;
      prem      <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      rdy       <= 1'b0;
      busy      <= 1'b0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      dq       <= dvd_abs;
      dvs_mag  <= dvs_abs;
      prem     <= '0;
      sign_q   <= dividend[2*DW-1] ^ divisor[DW-1];
      sign_r   <= dividend[2*DW-1];
      cnt      <= '0;
      rdy      <= 1'b0;
      busy     <= 1'b1;
      div_zero <= 1'b0;
      overflow <= 1'b0;
    end else if (state == CALC) begin
      dq   <= {dq[2*DW-2:0], fits};
      prem <= fits ? diff[DW-1:0] : shifted[DW-1:0];
      cnt  <= cnt + 1'b1;
    end else if (state == FIX) begin
      rdy  <= 1'b1;
      busy <= 1'b0;
      if (dvs_mag == '0) begin
        // dq still holds the dividend magnitude; re-signing its low bits
        // reproduces the dividend's low byte.
        div_zero  <= 1'b1;
        overflow  <= 1'b0;
        quotient  <= sign_r ? SAT_NEG : SAT_POS;
        remainder <= sign_r ? (~q_lo + 1'b1) : q_lo;
      end else begin
        div_zero  <= 1'b0;
        overflow  <= q_ovf;
        quotient  <= q_ovf ? (sign_q ? SAT_NEG : SAT_POS)
                           : (sign_q ? (~q_lo + 1'b1) : q_lo);
        remainder <= sign_r ? (~prem + 1'b1) : prem;
      end
    end
  end

endmodule

// File: tb/tb_booth_div_16by8.sv
// tb/tb_booth_div_16by8.sv - randomized self-checking bench for booth_div_16by8
module tb_booth_div_16by8;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        rdy;
  logic        busy;
  logic        div_zero;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  booth_div_16by8 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .rdy       (rdy),
    .busy      (busy),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division (truncates toward zero, remainder
  // takes the dividend's sign), then saturation and divide-by-zero rules.
  task automatic model(input logic [15:0] d, input logic [7:0] v,
                       output logic [7:0] eq, output logic [7:0] er,
                       output logic ez, output logic eo);
    int dv;
    int vv;
    int qt;
    int rt;
    dv = int'($signed(d));
    vv = int'($signed(v));
    if (vv == 0) begin
      ez = 1'b1;
      eo = 1'b0;
      eq = (dv < 0) ? 8'h80 : 8'h7F;
      er = d[7:0];
    end else begin
      qt = dv / vv;
      rt = dv % vv;
      ez = 1'b0;
      eo = (qt > 127) || (qt < -128);
      if (eo) eq = ((dv < 0) != (vv < 0)) ? 8'h80 : 8'h7F;
      else    eq = qt[7:0];
      er = rt[7:0];
    end
  endtask

  // One operation: start pulse, optional ignored start pulse at edge intr,
  // then latency, busy, result and hold checks.
  task automatic run_op(input logic [15:0] d, input logic [7:0] v, input int intr);
    logic [7:0] eq;
    logic [7:0] er;
    logic       ez;
    logic       eo;
    int         cycles;
    logic       busy_ok;
    model(d, v, eq, er, ez, eo);
    dividend = d;
    divisor  = v;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("accept_rdy_low", rdy, 1'b0);
    check("accept_busy", busy, 1'b1);
    cycles  = 0;
    busy_ok = 1'b1;
    while (!rdy && cycles < 40) begin
      if (intr > 0 && cycles == intr - 1) begin
        start    = 1'b1;
        dividend = 16'($urandom);
        divisor  = 8'($urandom_range(1, 255));
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cycles++;
      if (!rdy && !busy) busy_ok = 1'b0;
    end
    check("latency", cycles, (v == 8'h00) ? 17'd1 : 17'd17);
    check("busy_during", busy_ok, 1'b1);
    check("busy_done", busy, 1'b0);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_zero", div_zero, ez);
    check("overflow", overflow, eo);
    repeat (2) @(posedge clk);
    #1;
    check("hold", {quotient, remainder, rdy, busy}, {eq, er, 1'b1, 1'b0});
  endtask

  initial begin
    logic [7:0] r8;
    logic [15:0] d16;
    logic [7:0] v8;
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {quotient, remainder, rdy, busy, div_zero, overflow}, 20'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_release", {rdy, busy}, 2'b00);

    run_op(16'd100, 8'd7, 0);
    run_op(-16'sd100, 8'd7, 0);
    run_op(16'd100, -8'sd7, 0);
    run_op(-16'sd100, -8'sd7, 0);
    run_op(-16'sd1024, 8'd8, 0);
    run_op(16'd16384, 8'd2, 0);
    run_op(16'h8000, 8'hFF, 0);
    run_op(16'd127, 8'h80, 0);
    run_op(-16'sd5, 8'd0, 0);
    run_op(16'd300, 8'd0, 0);
    run_op(16'd100, 8'd7, 5);
    run_op(-16'sd1000, 8'd9, 5);

    // Reset in the middle of a calculation
    dividend = 16'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_outputs", {quotient, remainder, rdy, busy, div_zero, overflow}, 20'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check("released_outputs", {quotient, remainder, rdy, busy, div_zero, overflow}, 20'h0);
    repeat (20) @(posedge clk);
    #1;
    check("no_stale_result", {rdy, busy}, 2'b00);
    run_op(16'd100, 8'd7, 0);

    for (int i = 0; i < 200; i++) begin
      r8  = 8'($urandom);
      d16 = 16'($urandom);
      case (i % 3)
        0: d16 = {{8{r8[7]}}, r8};
        1: d16 = {{4{d16[11]}}, d16[11:0]};
        default: ;
      endcase
      v8 = 8'($urandom);
      if (i % 9 == 0) v8 = 8'h00;
      run_op(d16, v8, (i % 11 == 0) ? 3 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
